// File: rtl/rvmem_axi_bridge.sv
// rvmem_axi_bridge
//   Converts the RV32I core's valid/ready memory request stream into AXI4
//   master transactions. It supports INCR read bursts (line fills),
//   byte-masked single-beat writes and several outstanding transactions per
//   direction. Reads and writes never overlap on the bus. Traffic is gated
//   by a synchronised memory-calibration-done input.
//
// Ports
//   clock, reset          : system clock, asynchronous active-high reset
//   mem_init_done         : calibration complete (asynchronous to clock)
//   init_done, busy       : synchronised ready, any pending/outstanding work
//   req_*                 : core request channel (one holding register)
//   rsp_*                 : read data return (pass-through of AXI R)
//   wack_valid, wack_err  : write completion (pass-through of AXI B)
//   m_aw*, m_w*, m_b*     : AXI4 write address / data / response
//   m_ar*, m_r*           : AXI4 read address / data
module rvmem_axi_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 28,
  parameter int ID_WIDTH       = 4,
  parameter int AXI_ID         = 0,
  parameter int MAX_BURST      = 8,
  parameter int RD_OUTSTANDING = 4,
  parameter int WR_OUTSTANDING = 4,
  localparam int LEN_W         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int STRB_W        = DATA_WIDTH / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mem_init_done,
  output logic                      init_done,
  output logic                      busy,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [STRB_W-1:0]         req_wmask,
  input  logic [LEN_W-1:0]          req_len,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic                      wack_valid,
  output logic                      wack_err,
  output logic [ID_WIDTH-1:0]       m_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [STRB_W-1:0]         m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ID_WIDTH-1:0]       m_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int RD_CW = $clog2(RD_OUTSTANDING + 1);
  localparam int WR_CW = $clog2(WR_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t                    state, state_next;
  logic                      sync_q;
  logic [RD_CW-1:0]          rd_out;
  logic [WR_CW-1:0]          wr_out;
  logic                      aw_done_q, w_done_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_W-1:0]         wmask_q;
  logic [LEN_W-1:0]          len_q;

  logic accept, pending, ordering_ok, counter_ok;
  logic aw_hs, w_hs, ar_hs, r_final, b_hs;

  // Upper address bits and the low response bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{req_addr, m_rresp[0], m_bresp[0]};

  // Two-flop synchroniser for the calibration flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      sync_q    <= mem_init_done;
      init_done <= sync_q;
    end
  end

  // Acceptance depends only on registered state plus the request direction;
  // req_valid never feeds back into req_ready.
  assign pending     = (state != S_IDLE);
  assign ordering_ok = req_we ? (rd_out == '0) : (wr_out == '0);
  assign counter_ok  = req_we ? (wr_out < WR_CW'(WR_OUTSTANDING))
                              : (rd_out < RD_CW'(RD_OUTSTANDING));
  assign req_ready   = init_done & ~pending & ordering_ok & counter_ok;
  assign accept      = req_valid & req_ready;

  assign aw_hs   = m_awvalid & m_awready;
  assign w_hs    = m_wvalid & m_wready;
  assign ar_hs   = m_arvalid & m_arready;
  assign r_final = m_rvalid & rsp_ready & m_rlast;
  assign b_hs    = m_bvalid;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = req_we ? S_WR : S_RD;
      S_RD:   if (ar_hs) state_next = S_IDLE;
      S_WR:   if ((aw_hs | aw_done_q) & (w_hs | w_done_q)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: AW and W drop independently after their own handshake.
  always_comb begin
    m_arvalid = (state == S_RD);
    m_awvalid = (state == S_WR) & ~aw_done_q;
    m_wvalid  = (state == S_WR) & ~w_done_q;
  end

  // Holding register and per-channel handshake flags for the write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      len_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept) begin
      addr_q    <= req_addr[AXI_ADDR_WIDTH-1:0];
      wdata_q   <= req_wdata;
      wmask_q   <= req_wmask;
      len_q     <= req_len;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
    end
  end

  // Outstanding counters; simultaneous issue and completion cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_out <= '0;
      wr_out <= '0;
    end else begin
      case ({ar_hs, r_final})
        2'b10:   rd_out <= rd_out + RD_CW'(1);
        2'b01:   rd_out <= rd_out - RD_CW'(1);
        default: rd_out <= rd_out;
      endcase
      case ({aw_hs, b_hs})
        2'b10:   wr_out <= wr_out + WR_CW'(1);
        2'b01:   wr_out <= wr_out - WR_CW'(1);
        default: wr_out <= wr_out;
      endcase
    end
  end

  assign busy = pending | (rd_out != '0) | (wr_out != '0);

  assign m_arid    = ID_WIDTH'(AXI_ID);
  assign m_araddr  = addr_q;
  assign m_arlen   = 8'(len_q);
  assign m_arsize  = 3'($clog2(STRB_W));
  assign m_arburst = 2'b01;

  assign m_awid    = ID_WIDTH'(AXI_ID);
  assign m_awaddr  = addr_q;
  assign m_awlen   = 8'd0;
  assign m_awsize  = 3'($clog2(STRB_W));
  assign m_awburst = 2'b01;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wmask_q;
  assign m_wlast   = 1'b1;

  // Read and write returns are pure pass-throughs under the single ID.
  assign rsp_valid  = m_rvalid;
  assign m_rready   = rsp_ready;
  assign rsp_data   = m_rdata;
  assign rsp_last   = m_rlast;
  assign rsp_err    = m_rresp[1];
  assign m_bready   = 1'b1;
  assign wack_valid = m_bvalid;
  assign wack_err   = m_bresp[1];

endmodule
